vjtag_reg_ctrl: RTL and testbench
=================================

// Module: vjtag_reg_ctrl
// PURPOSE
//  Sequencer behind the virtual JTAG hub. It decodes the latched IR opcode and runs each DR scan through capture, shift and update.
//  It commits shifted words into a small register file and returns register or status contents on TDO.
//  Sits between the vjtag megafunction (tck/tdi/ir_in/virtual_state_*) and board logic; regs_out[7:0] drives LED[7:0].
// PARAMETERS
//  IR_W    2   width of ir_in
//  DW      8   data word / DR length in bits
//  NREG    4   register-file depth; power of two
//  AW      2   address width = log2(NREG)
// PORTS
//  tck        in   1        JTAG clock from vjtag; sole clock
//  rst_n      in   1        async active-low reset
//  ir_in      in   IR_W     virtual IR value
//  tdi        in   1        serial data in
//  v_cdr      in   1        virtual_state_cdr
//  v_sdr      in   1        virtual_state_sdr
//  v_udr      in   1        virtual_state_udr
//  status_in  in   DW       board status word, returned by WRITE capture
//  tdo        out  1        serial data out
//  regs_out   out  NREG*DW  flattened register file, reg k at [k*DW +: DW]
//  wr_stb     out  1        one-tck pulse on a committed register write
//  wr_addr    out  AW       address of the write flagged by wr_stb
//  err        out  1        sticky: a scan ended with bit count != DW
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, regs 0, addr 0, FSM S_IDLE, shift reg 0, bit count 0, err 0.
//  - Opcodes: 0 BYPASS; 1 SET_ADDR; 2 WRITE; 3 READ. Opcode is latched at v_cdr; ir_in changes mid-scan are ignored.
//  - FSM S_IDLE -> S_SCAN on v_cdr. In S_SCAN, v_sdr shifts; e1/pause/e2 hold state.
//    S_SCAN -> S_IDLE on v_udr (commit). A v_udr seen in S_IDLE is ignored.
//  - Capture (v_cdr edge), loads shift reg sr:
//    READ = regs[addr]; SET_ADDR = addr zero-extended; WRITE = status_in; BYPASS = 0. Bit count cleared.
//  - Shift (v_sdr): sr <= {tdi, sr[DW-1:1]}, LSB first. tdo = sr[0], registered on tck.
//    BYPASS uses a 1-bit register: tdo = tdi delayed one tck.
//    Bit count saturates at DW+1.
//  - Update (v_udr in S_SCAN):
//    - Bit count == DW: SET_ADDR sets addr = sr[AW-1:0].
//      WRITE sets regs[addr] = sr and pulses wr_stb/wr_addr on the next tck. READ and BYPASS have no side effect.
//    - Bit count != DW, opcode != BYPASS: no commit; err set. err clears only on reset.
//  - Addr wraps modulo NREG.
//  - Write latency: v_udr edge -> regs_out valid and wr_stb high on the same following tck edge.
//  - v_cdr and v_udr asserted together (illegal): v_cdr wins, pending update discarded.
//  - Reset mid-scan aborts the scan; nothing is committed.
// CONFIGURATION
//  - VJTAG_AUTO_INC_EN defined: after each committed WRITE or completed READ (count == DW), addr <= addr+1, wrapping NREG-1 -> 0.
//    Consecutive scans then stream through the register file.
//  - Undefined: addr changes only via SET_ADDR.
// STRUCTURE
//  - Package vjtag_pkg holds the opcode constants (OP_BYPASS/OP_SET_ADDR/OP_WRITE/OP_READ), the FSM state encoding and the default DW/IR_W.
//  - Sub-module vjtag_dr_shift holds the shift register, bit counter and tdo register.
//    Its ports are capture load/value, shift, tdi, tdo and count_ok.
//  - Opcode decode, FSM, address and register file stay in vjtag_reg_ctrl.
// TESTING
//  - Reset: rst_n=0 mid-shift -> tdo=0, regs_out=0, err=0, wr_stb=0. No commit on the following v_udr.
//  - SET_ADDR 8'h02 then WRITE 8'hA5 (8 shifts) -> regs_out[23:16]=8'hA5, wr_stb 1 tck with wr_addr=2.
//  - READ at addr 2 -> tdo serial 1,0,1,0,0,1,0,1 (LSB first of A5). Registers unchanged.
//  - WRITE with 7 shifts, then 9 shifts -> regs unchanged, err=1 after the first scan and stays 1.
//  - With VJTAG_AUTO_INC_EN: SET_ADDR 3, WRITE 8'h11, WRITE 8'h22 -> reg3=8'h11, reg0=8'h22 (wrap).
//    Without the macro: reg3=8'h22.
//  - BYPASS: tdi pattern 1,1,0 -> tdo 1,1,0 delayed one tck; ir_in switched to 3 mid-scan -> no side effect.

Source files
------------

// File: rtl/vjtag_pkg.sv
// Shared definitions for the virtual-JTAG register sequencer: opcode values,
// scan FSM encoding and default widths.
package vjtag_pkg;

    localparam int DEF_IR_W = 2;
    localparam int DEF_DW   = 8;
    localparam int DEF_NREG = 4;

    // Virtual IR opcodes (only the two low IR bits are decoded)
    typedef enum logic [1:0] {
        OP_BYPASS   = 2'd0,
        OP_SET_ADDR = 2'd1,
        OP_WRITE    = 2'd2,
        OP_READ     = 2'd3
    } opcode_e;

    // Scan sequencer states
    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_e;

    // Map raw IR bits onto an opcode
    function automatic opcode_e decode_op(input logic [1:0] ir);
        return opcode_e'(ir);
    endfunction

endpackage

// File: rtl/vjtag_reg_ctrl_if.sv
// JTAG-side bundle between the vjtag hub (master) and the register
// sequencer (slave): IR value, serial data and the virtual TAP state strobes.
interface vjtag_reg_ctrl_if #(
    parameter int IR_W = 2
);
    logic [IR_W-1:0] ir_in;
    logic            tdi;
    logic            v_cdr;
    logic            v_sdr;
    logic            v_udr;
    logic            tdo;

    modport master (
        output ir_in, tdi, v_cdr, v_sdr, v_udr,
        input  tdo
    );

    modport slave (
        input  ir_in, tdi, v_cdr, v_sdr, v_udr,
        output tdo
    );
endinterface

// File: rtl/vjtag_dr_shift.sv
// DR shift path: parallel-load shift register (LSB first), saturating bit
// counter and a tdo register that always mirrors the current sr[0].
module vjtag_dr_shift #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          capture,
    input  logic [DW-1:0] cap_value,
    input  logic          shift,
    input  logic          tdi,
    output logic          tdo,
    output logic [DW-1:0] data,
    output logic          count_ok
);
    // Counter must hold DW+1 so overlong scans stay distinguishable
    localparam int CW = $clog2(DW + 2);

    logic [DW-1:0] sr_reg;
    logic [DW-1:0] sr_next;
    logic [CW-1:0] count_reg;
    logic          tdo_reg;

    assign sr_next = {tdi, sr_reg[DW-1:1]};

    // Load on capture, shift on sdr; tdo follows the bit that will be presented next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg    <= '0;
            count_reg <= '0;
            tdo_reg   <= 1'b0;
        end else if (capture) begin
            sr_reg    <= cap_value;
            count_reg <= '0;
            tdo_reg   <= cap_value[0];
        end else if (shift) begin
            sr_reg  <= sr_next;
            tdo_reg <= sr_next[0];
            if (count_reg != CW'(DW + 1)) begin
                count_reg <= count_reg + CW'(1);
            end
        end
    end

    assign tdo      = tdo_reg;
    assign data     = sr_reg;
    assign count_ok = (count_reg == CW'(DW));

endmodule

// File: rtl/vjtag_reg_ctrl.sv
// Virtual-JTAG register sequencer: latches the IR opcode at capture, runs the
// DR scan through vjtag_dr_shift and commits full-length scans into a small
// register file. Short/long scans on non-BYPASS opcodes set a sticky err.
// Optional build macro VJTAG_AUTO_INC_EN: advance addr after every committed
// WRITE or completed READ so consecutive scans stream through the registers.
module vjtag_reg_ctrl
    import vjtag_pkg::*;
#(
    parameter int IR_W = DEF_IR_W,
    parameter int DW   = DEF_DW,
    parameter int NREG = DEF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic               tck,
    input  logic               rst_n,
    vjtag_reg_ctrl_if.slave    jtag,
    input  logic [DW-1:0]      status_in,
    output logic [NREG*DW-1:0] regs_out,
    output logic               wr_stb,
    output logic [AW-1:0]      wr_addr,
    output logic               err
);

    state_e          state_reg;
    opcode_e         opcode_reg;
    logic [AW-1:0]   addr_reg;
    logic            wr_stb_reg;
    logic [AW-1:0]   wr_addr_reg;
    logic            err_reg;
    logic            byp_reg;

    logic [IR_W-1:0] ir_val;
    opcode_e         ir_op;
    logic [DW-1:0]   cap_value;
    logic [DW-1:0]   sr_data;
    logic            dr_tdo;
    logic            count_ok;
    logic            capture;
    logic            shift_en;
    logic            do_update;
    logic            wr_commit;

    assign ir_val = jtag.ir_in;
    assign ir_op  = decode_op(ir_val[1:0]);

    // Capture always wins; a simultaneous udr is dropped
    assign capture   = jtag.v_cdr;
    assign shift_en  = jtag.v_sdr && !jtag.v_cdr && (state_reg == S_SCAN);
    assign do_update = jtag.v_udr && !jtag.v_cdr && (state_reg == S_SCAN);
    assign wr_commit = do_update && count_ok && (opcode_reg == OP_WRITE);

    // Select the word presented on TDO for the opcode being captured
    always_comb begin
        cap_value = '0;
        case (ir_op)
            OP_READ:     cap_value = sr_read_word(addr_reg);
            OP_SET_ADDR: cap_value = DW'(addr_reg);
            OP_WRITE:    cap_value = status_in;
            default:     cap_value = '0;
        endcase
    end

    vjtag_dr_shift #(
        .DW(DW)
    ) u_dr_shift (
        .clk       (tck),
        .rst_n     (rst_n),
        .capture   (capture),
        .cap_value (cap_value),
        .shift     (shift_en),
        .tdi       (jtag.tdi),
        .tdo       (dr_tdo),
        .data      (sr_data),
        .count_ok  (count_ok)
    );

    // Scan sequencer: opcode latch, address, bypass bit, write strobe and err
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            opcode_reg  <= OP_BYPASS;
            addr_reg    <= '0;
            wr_stb_reg  <= 1'b0;
            wr_addr_reg <= '0;
            err_reg     <= 1'b0;
            byp_reg     <= 1'b0;
        end else begin
            wr_stb_reg <= 1'b0;
            if (capture) begin
                state_reg  <= S_SCAN;
                opcode_reg <= ir_op;
                byp_reg    <= 1'b0;
            end else begin
                if (shift_en) begin
                    byp_reg <= jtag.tdi;
                end
                if (do_update) begin
                    state_reg <= S_IDLE;
                    if (count_ok) begin
                        case (opcode_reg)
                            OP_SET_ADDR: addr_reg <= sr_data[AW-1:0];
                            OP_WRITE: begin
                                wr_stb_reg  <= 1'b1;
                                wr_addr_reg <= addr_reg;
`ifdef VJTAG_AUTO_INC_EN
                                addr_reg    <= addr_reg + AW'(1);
`endif
                            end
                            OP_READ: begin
`ifdef VJTAG_AUTO_INC_EN
                                addr_reg <= addr_reg + AW'(1);
`endif
                            end
                            default: ;
                        endcase
                    end else if (opcode_reg != OP_BYPASS) begin
                        err_reg <= 1'b1;
                    end
                end
            end
        end
    end

    // Register file kept in flops since every word is visible on regs_out
    logic [DW-1:0] regs_view [NREG];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic [DW-1:0] word_reg;

            // Commit a full-length WRITE scan into the addressed word
            always_ff @(posedge tck or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (wr_commit && (addr_reg == AW'(gi))) begin
                    word_reg <= sr_data;
                end
            end

            assign regs_view[gi]          = word_reg;
            assign regs_out[gi*DW +: DW]  = word_reg;
        end
    endgenerate

    function automatic logic [DW-1:0] sr_read_word(input logic [AW-1:0] a);
        return regs_view[a];
    endfunction

    assign jtag.tdo = (opcode_reg == OP_BYPASS) ? byp_reg : dr_tdo;
    assign wr_stb   = wr_stb_reg;
    assign wr_addr  = wr_addr_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_vjtag_reg_ctrl.sv
// Randomized self-checking bench for vjtag_reg_ctrl against a word-level
// model of the register file, address and sticky error flag.
module tb_vjtag_reg_ctrl;

    logic        tck;
    logic        rst_n;
    logic [7:0]  status_in;
    logic [31:0] regs_out;
    logic        wr_stb;
    logic [1:0]  wr_addr;
    logic        err;

    vjtag_reg_ctrl_if #(.IR_W(2)) jtag ();

    vjtag_reg_ctrl #(
        .IR_W(2), .DW(8), .NREG(4), .AW(2)
    ) dut (
        .tck       (tck),
        .rst_n     (rst_n),
        .jtag      (jtag),
        .status_in (status_in),
        .regs_out  (regs_out),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .err       (err)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0] regs_m [4];
    logic [1:0] addr_m;
    logic       err_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_flat();
        return {regs_m[3], regs_m[2], regs_m[1], regs_m[0]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) regs_m[k] = 8'h00;
        addr_m = 2'd0;
        err_m  = 1'b0;
    endtask

    task automatic model_step_addr();
`ifdef VJTAG_AUTO_INC_EN
        addr_m = 2'((int'(addr_m) + 1) % 4);
`endif
    endtask

    // One complete DR scan: capture, nbits shifts (optional pause gaps), update
    task automatic do_scan(input logic [1:0] op, input logic [15:0] din, input int nbits,
                           input bit gaps, output logic [15:0] tdo_bits);
        logic [23:0] stream;
        logic [7:0]  cap;
        logic        prev_tdi;
        logic        exp_tdo;
        bit          exp_stb;
        logic [1:0]  exp_waddr;

        status_in = 8'($urandom);
        @(negedge tck);
        jtag.ir_in = op;
        jtag.v_cdr = 1'b1;
        case (op)
            2'd3:    cap = regs_m[addr_m];
            2'd1:    cap = {6'b0, addr_m};
            2'd2:    cap = status_in;
            default: cap = 8'h00;
        endcase
        stream = {din, cap};
        @(negedge tck);
        jtag.v_cdr = 1'b0;
        jtag.ir_in = 2'($urandom);        // opcode must stay latched
        prev_tdi   = 1'b0;
        tdo_bits   = '0;
        exp_waddr  = 2'd0;
        for (int i = 0; i < nbits; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                jtag.v_sdr = 1'b0;
                @(negedge tck);
            end
            exp_tdo     = (op == 2'd0) ? prev_tdi : stream[i];
            tdo_bits[i] = jtag.tdo;
            check("tdo", 64'(jtag.tdo), 64'(exp_tdo));
            jtag.tdi   = din[i];
            jtag.v_sdr = 1'b1;
            prev_tdi   = din[i];
            @(negedge tck);
        end
        jtag.v_sdr = 1'b0;
        exp_tdo = (op == 2'd0) ? prev_tdi : stream[nbits];
        check("tdo_tail", 64'(jtag.tdo), 64'(exp_tdo));
        jtag.v_udr = 1'b1;

        exp_stb = 1'b0;
        if (nbits == 8) begin
            case (op)
                2'd1: addr_m = din[1:0];
                2'd2: begin
                    regs_m[addr_m] = din[7:0];
                    exp_stb   = 1'b1;
                    exp_waddr = addr_m;
                    model_step_addr();
                end
                2'd3: model_step_addr();
                default: ;
            endcase
        end else if (op != 2'd0) begin
            err_m = 1'b1;
        end

        @(negedge tck);
        jtag.v_udr = 1'b0;
        check("wr_stb", 64'(wr_stb), 64'(exp_stb));
        if (exp_stb) check("wr_addr", 64'(wr_addr), 64'(exp_waddr));
        check("regs", 64'(regs_out), 64'(model_flat()));
        check("err", 64'(err), 64'(err_m));
        @(negedge tck);
        check("wr_stb_pulse", 64'(wr_stb), 64'(0));
        $display("scan op=%0d bits=%0d din=%04h tdo=%04h regs=%08h addr=%0d err=%0b",
                 op, nbits, din, tdo_bits, regs_out, addr_m, err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] tb_bits;
        int r;
        int nb;

        rst_n      = 1'b0;
        status_in  = 8'h00;
        jtag.ir_in = 2'd0;
        jtag.tdi   = 1'b0;
        jtag.v_cdr = 1'b0;
        jtag.v_sdr = 1'b0;
        jtag.v_udr = 1'b0;
        model_reset();
        repeat (3) @(negedge tck);
        rst_n = 1'b1;
        check("rst_tdo", 64'(jtag.tdo), 64'(0));
        check("rst_regs", 64'(regs_out), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_wr_stb", 64'(wr_stb), 64'(0));
        check("rst_wr_addr", 64'(wr_addr), 64'(0));

        // SET_ADDR 2 then WRITE A5
        do_scan(2'd1, 16'h0002, 8, 1'b0, tb_bits);
        do_scan(2'd2, 16'h00A5, 8, 1'b1, tb_bits);
        check("reg2_a5", 64'(regs_out[23:16]), 64'(8'hA5));

        // READ back address 2: serial 1,0,1,0,0,1,0,1
        do_scan(2'd1, 16'h0002, 8, 1'b0, tb_bits);
        do_scan(2'd3, 16'($urandom), 8, 1'b1, tb_bits);
        check("read_a5", 64'(tb_bits[7:0]), 64'(8'hA5));

        // BYPASS 1,1,0 with ir_in scrambled mid-scan
        do_scan(2'd0, 16'h0003, 3, 1'b0, tb_bits);
        check("byp_bits", 64'(tb_bits[2:0]), 64'(3'b110));

        // streaming writes around the top of the register file
        do_scan(2'd1, 16'h0003, 8, 1'b0, tb_bits);
        do_scan(2'd2, 16'h0011, 8, 1'b0, tb_bits);
        do_scan(2'd2, 16'h0022, 8, 1'b0, tb_bits);
`ifdef VJTAG_AUTO_INC_EN
        check("inc_reg3", 64'(regs_out[31:24]), 64'(8'h11));
        check("inc_reg0", 64'(regs_out[7:0]), 64'(8'h22));
`else
        check("noinc_reg3", 64'(regs_out[31:24]), 64'(8'h22));
`endif

        // wrong-length WRITE scans: no commit, sticky err
        do_scan(2'd2, 16'h005A, 7, 1'b0, tb_bits);
        check("err_short", 64'(err), 64'(1));
        do_scan(2'd2, 16'h01C3, 9, 1'b1, tb_bits);
        check("err_long", 64'(err), 64'(1));

        // randomized scans
        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 9);
            nb = (r < 7) ? 8 : (r == 7) ? 7 : (r == 8) ? 9 : 0;
            do_scan(2'($urandom), 16'($urandom), nb, 1'b1, tb_bits);
        end

        // reset in the middle of a WRITE shift
        @(negedge tck);
        jtag.ir_in = 2'd2;
        jtag.v_cdr = 1'b1;
        @(negedge tck);
        jtag.v_cdr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            jtag.tdi   = 1'($urandom);
            jtag.v_sdr = 1'b1;
            @(negedge tck);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_tdo", 64'(jtag.tdo), 64'(0));
        check("mid_rst_regs", 64'(regs_out), 64'(0));
        check("mid_rst_err", 64'(err), 64'(0));
        check("mid_rst_wr_stb", 64'(wr_stb), 64'(0));
        @(negedge tck);
        jtag.v_sdr = 1'b0;
        rst_n      = 1'b1;
        jtag.v_udr = 1'b1;
        @(negedge tck);
        jtag.v_udr = 1'b0;
        check("post_rst_regs", 64'(regs_out), 64'(0));
        check("post_rst_wr_stb", 64'(wr_stb), 64'(0));
        check("post_rst_err", 64'(err), 64'(0));
        $display("reset mid-scan regs=%08h err=%0b", regs_out, err);

        // normal operation after reset
        do_scan(2'd1, 16'h0001, 8, 1'b0, tb_bits);
        do_scan(2'd2, 16'($urandom), 8, 1'b1, tb_bits);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
